// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM request controller and its RAM_SP_64_8 neighbour.
package ram_ctrl_pkg;

   localparam int RAM_ADDR_W = 6;
   localparam int RAM_DATA_W = 16;

   localparam logic RAM_RD = 1'b0;
   localparam logic RAM_WR = 1'b1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ACC0 = 3'd1,
      ACC1 = 3'd2,
      WAIT = 3'd3,
      RESP = 3'd4
   } state_t;

endpackage

// File: rtl/ram_req_ctrl.sv
// Sequences 16/32-bit load/store requests into halfword accesses on a single-port RAM
// and returns reassembled load data over a valid/ready response channel.
module ram_req_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic                  req_word,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [2*DATA_W-1:0]   req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [2*DATA_W-1:0]   rsp_rdata,
   output logic [ADDR_W-1:0]     ram_add,
   output logic [DATA_W-1:0]     ram_data_in,
   output logic                  ram_r_w,
   output logic                  ram_enable,
   output logic                  ram_ce,
   input  logic [DATA_W-1:0]     ram_data_out
);

   state_t                state_q, state_d;
   logic                  we_q, we_d;
   logic                  word_q, word_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [2*DATA_W-1:0]   wdata_q, wdata_d;
   logic [2*DATA_W-1:0]   rdata_q, rdata_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  req_ready_q, req_ready_d;
   logic [ADDR_W-1:0]     ram_add_q, ram_add_d;
   logic [DATA_W-1:0]     ram_din_q, ram_din_d;
   logic                  ram_rw_q, ram_rw_d;
   logic                  ram_en_q, ram_en_d;

   // Next-state, request latching and read-data capture.
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      word_d  = word_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               word_d  = req_word;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               state_d = ACC0;
            end else begin
               state_d = IDLE;
            end
         end
         ACC0: begin
            if (word_q) begin
               state_d = ACC1;
            end else if (we_q) begin
               state_d = RESP;
               rdata_d = {(2*DATA_W){1'b0}};
            end else begin
               state_d = WAIT;
            end
         end
         ACC1: begin
            if (we_q) begin
               state_d = RESP;
               rdata_d = {(2*DATA_W){1'b0}};
            end else begin
               state_d = WAIT;
               rdata_d[DATA_W-1:0] = ram_data_out;
            end
         end
         WAIT: begin
            state_d = RESP;
            // Halfword loads overwrite the whole word so stale upper data never leaks.
            if (word_q) begin
               rdata_d[2*DATA_W-1:DATA_W] = ram_data_out;
            end else begin
               rdata_d = {{DATA_W{1'b0}}, ram_data_out};
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // RAM strobe and handshake outputs are decoded from the next state so they arrive registered.
   always_comb begin
      ram_en_d  = 1'b0;
      ram_add_d = {ADDR_W{1'b0}};
      ram_din_d = {DATA_W{1'b0}};
      ram_rw_d  = RAM_RD;
      case (state_d)
         ACC0: begin
            ram_en_d  = 1'b1;
            ram_add_d = addr_d;
            ram_din_d = wdata_d[DATA_W-1:0];
            ram_rw_d  = we_d ? RAM_WR : RAM_RD;
         end
         ACC1: begin
            ram_en_d  = 1'b1;
            ram_add_d = addr_d + {{(ADDR_W-1){1'b0}}, 1'b1};
            ram_din_d = wdata_d[2*DATA_W-1:DATA_W];
            ram_rw_d  = we_d ? RAM_WR : RAM_RD;
         end
         default: begin
            ram_en_d  = 1'b0;
         end
      endcase
      rsp_valid_d = (state_d == RESP);
      req_ready_d = (state_d == IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         word_q      <= 1'b0;
         addr_q      <= {ADDR_W{1'b0}};
         wdata_q     <= {(2*DATA_W){1'b0}};
         rdata_q     <= {(2*DATA_W){1'b0}};
         rsp_valid_q <= 1'b0;
         req_ready_q <= 1'b1;
         ram_add_q   <= {ADDR_W{1'b0}};
         ram_din_q   <= {DATA_W{1'b0}};
         ram_rw_q    <= 1'b0;
         ram_en_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         word_q      <= word_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         rsp_valid_q <= rsp_valid_d;
         req_ready_q <= req_ready_d;
         ram_add_q   <= ram_add_d;
         ram_din_q   <= ram_din_d;
         ram_rw_q    <= ram_rw_d;
         ram_en_q    <= ram_en_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rdata_q;
   assign ram_add     = ram_add_q;
   assign ram_data_in = ram_din_q;
   assign ram_r_w     = ram_rw_q;
   assign ram_enable  = ram_en_q;
   assign ram_ce      = ram_en_q;

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Scoreboard bench for ram_req_ctrl with a behavioural 64x16 registered-read RAM.
module tb_ram_req_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_word;
   logic [5:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic [5:0]  ram_add;
   logic [15:0] ram_data_in, ram_data_out;
   logic        ram_r_w, ram_enable, ram_ce;

   always #5 clk = ~clk;

   ram_req_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_word(req_word),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .ram_add(ram_add), .ram_data_in(ram_data_in), .ram_r_w(ram_r_w),
      .ram_enable(ram_enable), .ram_ce(ram_ce), .ram_data_out(ram_data_out)
   );

   // RAM model with a bench-side preload port
   logic [15:0] mem [0:63];
   logic        pl_en;
   logic [5:0]  pl_addr;
   logic [15:0] pl_data;

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (ram_enable) begin
         if (ram_r_w) mem[ram_add] <= ram_data_in;
         else ram_data_out <= mem[ram_add];
      end
   end

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int nrsp = 0;
   logic [31:0] exp_q[$];
   int lat_q[$];
   int acc_hist[$];
   int hs_hist[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: records handshakes and checks every new response against the scoreboard
   initial begin : monitor
      logic        prev_valid;
      logic [31:0] e;
      int          l;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_valid = 1'b0;
         end else begin
            if (req_valid && req_ready) begin
               acc_cyc = cyc + 1;
               acc_hist.push_back(cyc + 1);
            end
            if (rsp_valid && rsp_ready) hs_hist.push_back(cyc + 1);
            if (rsp_valid && !prev_valid) begin
               nrsp++;
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_rsp: got rdata %h with nothing expected", rsp_rdata);
               end else begin
                  e = exp_q.pop_front();
                  l = lat_q.pop_front();
                  chk("rsp_rdata", rsp_rdata, e);
                  chk("rsp_latency", cyc - acc_cyc, l);
               end
            end
            prev_valid = rsp_valid;
            chk("ce_eq_enable", {31'b0, ram_ce}, {31'b0, ram_enable});
            chk("strobe_outside_acc", {31'b0, ram_enable && (req_ready || rsp_valid)}, 32'd0);
            if (!ram_enable) chk("ram_idle_zero", {9'b0, ram_r_w, ram_add, ram_data_in}, 32'd0);
         end
      end
   end

   task automatic preload(input logic [5:0] a, input logic [15:0] d);
      @(posedge clk); #1;
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic send(input logic we, input logic word, input logic [5:0] a, input logic [31:0] wd);
      int n;
      @(posedge clk); #1;
      req_we = we; req_word = word; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!req_ready) begin
         total++; bad++;
         $display("FAIL accept_timeout: req_ready stayed %b, expected 1", req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      int n;
      n = 0;
      while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
      if (!rsp_valid) begin
         total++; bad++;
         $display("FAIL rsp_timeout: rsp_valid stayed %b, expected 1", rsp_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic txn(input logic we, input logic word, input logic [5:0] a,
                      input logic [31:0] wd, input logic [31:0] exp, input int lat);
      exp_q.push_back(exp);
      lat_q.push_back(lat);
      send(we, word, a, wd);
      wait_rsp();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n, base, hbase, nrsp0;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_word = 1'b0;
      req_addr = 6'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
      pl_en = 1'b0; pl_addr = 6'd0; pl_data = 16'd0;
      #22;
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_ram", {8'b0, ram_enable, ram_r_w, ram_add, ram_data_in}, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      txn(1'b1, 1'b0, 6'd5,  32'h0000_BEEF, 32'h0000_0000, 1);
      txn(1'b0, 1'b0, 6'd5,  32'h0,         32'h0000_BEEF, 2);
      chk("mem5", {16'b0, mem[5]}, 32'h0000_BEEF);
      txn(1'b1, 1'b1, 6'd10, 32'h1234_5678, 32'h0000_0000, 2);
      chk("mem10", {16'b0, mem[10]}, 32'h0000_5678);
      chk("mem11", {16'b0, mem[11]}, 32'h0000_1234);
      txn(1'b0, 1'b1, 6'd10, 32'h0,         32'h1234_5678, 3);
      txn(1'b0, 1'b0, 6'd10, 32'h0,         32'h0000_5678, 2);
      txn(1'b1, 1'b1, 6'd63, 32'hAAAA_5555, 32'h0000_0000, 2);
      chk("mem63", {16'b0, mem[63]}, 32'h0000_5555);
      chk("mem0_wrap", {16'b0, mem[0]}, 32'h0000_AAAA);
      txn(1'b0, 1'b1, 6'd63, 32'h0,         32'hAAAA_5555, 3);

      // Backpressure: response held, stray request ignored
      preload(6'd30, 16'h0000);
      rsp_ready = 1'b0;
      exp_q.push_back(32'h1234_5678); lat_q.push_back(3);
      send(1'b0, 1'b1, 6'd10, 32'h0);
      n = 0;
      while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            req_valid = 1'b1; req_we = 1'b1; req_word = 1'b0;
            req_addr = 6'd30; req_wdata = 32'hFFFF_FFFF;
         end else begin
            req_valid = 1'b0;
         end
         chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
         chk("bp_rsp_rdata", rsp_rdata, 32'h1234_5678);
         chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
         chk("bp_no_strobe", {31'b0, ram_enable}, 32'd0);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_back_idle", {31'b0, req_ready}, 32'd1);
      chk("bp_mem30_untouched", {16'b0, mem[30]}, 32'h0000_0000);

      // Reset during ACC1 of a word store
      preload(6'd20, 16'h0000);
      preload(6'd21, 16'h1111);
      nrsp0 = nrsp;
      send(1'b1, 1'b1, 6'd20, 32'hCAFE_F00D);
      @(posedge clk); #1;
      chk("acc1_strobe", {31'b0, ram_enable}, 32'd1);
      chk("acc1_addr", {26'b0, ram_add}, 32'd21);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ram", {8'b0, ram_enable, ram_ce, ram_r_w, ram_add, ram_data_in}, 32'd0);
      chk("mid_rst_rsp", {rsp_valid, rsp_rdata[30:0]}, 32'd0);
      chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("rst_mem20", {16'b0, mem[20]}, 32'h0000_F00D);
      chk("rst_mem21", {16'b0, mem[21]}, 32'h0000_1111);
      chk("rst_no_rsp", nrsp - nrsp0, 32'd0);

      // Back-to-back halfword loads with req_valid held high
      base = acc_hist.size();
      hbase = hs_hist.size();
      nrsp0 = nrsp;
      exp_q.push_back(32'h0000_BEEF); lat_q.push_back(2);
      exp_q.push_back(32'h0000_BEEF); lat_q.push_back(2);
      @(posedge clk); #1;
      req_we = 1'b0; req_word = 1'b0; req_addr = 6'd5; req_wdata = 32'h0; req_valid = 1'b1;
      n = 0;
      while (acc_hist.size() < base + 2 && n < 100) begin @(posedge clk); #1; n++; end
      req_valid = 1'b0;
      n = 0;
      while (nrsp < nrsp0 + 2 && n < 100) begin @(posedge clk); #1; n++; end
      repeat (3) @(posedge clk);
      #1;
      if (acc_hist.size() >= base + 2 && hs_hist.size() >= hbase + 1) begin
         chk("b2b_accept_after_idle", acc_hist[base+1] - hs_hist[hbase], 32'd1);
         chk("b2b_accept_spacing", acc_hist[base+1] - acc_hist[base], 32'd4);
      end else begin
         total++; bad++;
         $display("FAIL b2b_handshakes: got %0d accepts %0d resp handshakes, expected 2 and 1",
                  acc_hist.size() - base, hs_hist.size() - hbase);
      end

      repeat (4) @(posedge clk);
      #1;
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      chk("rsp_count", nrsp, 32'd10);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
